key_event: RTL and testbench

KEY_EVENT -- requirements
Module: key_event

---
 rtl/key_event.sv | 166 ++++++++++++++++
 tb/tb_key_event.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/key_event.sv
// Keypad event generator: debounces a raw scan code, emits a single-cycle
// event on an accepted press, auto-repeats while the key stays held and
// tracks the held level until the release has been debounced.
module key_event #(
  parameter int DEB_CYC = 320000,
  parameter int REP_DLY = 16000000,
  parameter int REP_PER = 3200000
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic [4:0] key_code,
  output logic       key_evt,
  output logic [4:0] key_val,
  output logic       key_rep,
  output logic       key_down
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int MAXC = max3(DEB_CYC, REP_DLY, REP_PER);
  localparam int CW   = $clog2(MAXC + 1);

  // Terminal counts. The press/release debounce includes the sample that
  // caused the state entry, so it terminates one count earlier than the
  // repeat timers, which count only edges after entry.
  localparam logic [CW-1:0] DEB_TC = CW'(DEB_CYC - 2);
  localparam logic [CW-1:0] DLY_TC = CW'(REP_DLY - 1);
  localparam logic [CW-1:0] PER_TC = CW'(REP_PER - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    REPEAT,
    DEB_REL
  } state_t;

  // Codes above the keypad range are indistinguishable from no key.
  function automatic logic [4:0] sanitize(input logic [4:0] c);
    return (c > 5'd16) ? 5'd0 : c;
  endfunction

  // Saturating increment so the shared counter can never wrap.
  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + CW'(1);
  endfunction

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [4:0]    cand, cand_nx;
  logic [4:0]    code;
  logic          match;
  logic          evt_nx;
  logic [4:0]    val_nx;
  logic          rep_nx;
  logic          down_nx;

  assign code  = sanitize(key_code);
  assign match = (code == cand);

  // State, counter, candidate and all outputs are registered together.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cand     <= '0;
      key_evt  <= 1'b0;
      key_val  <= '0;
      key_rep  <= 1'b0;
      key_down <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      cand     <= cand_nx;
      key_evt  <= evt_nx;
      key_val  <= val_nx;
      key_rep  <= rep_nx;
      key_down <= down_nx;
    end
  end

  // Next-state, counter and output decode; outputs hold unless an event
  // or an accepted release changes them.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    evt_nx   = 1'b0;
    val_nx   = key_val;
    rep_nx   = key_rep;
    down_nx  = key_down;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (code != 5'd0) begin
          cand_nx  = code;
          state_nx = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (!match) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == DEB_TC) begin
          evt_nx   = 1'b1;
          val_nx   = cand;
          rep_nx   = 1'b0;
          down_nx  = 1'b1;
          state_nx = HELD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc(cnt);
        end
      end
      HELD: begin
        if (!match) begin
          state_nx = DEB_REL;
          cnt_nx   = '0;
        end else if (cnt == DLY_TC) begin
          evt_nx   = 1'b1;
          val_nx   = cand;
          rep_nx   = 1'b1;
          state_nx = REPEAT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc(cnt);
        end
      end
      REPEAT: begin
        if (!match) begin
          state_nx = DEB_REL;
          cnt_nx   = '0;
        end else if (cnt == PER_TC) begin
          evt_nx = 1'b1;
          val_nx = cand;
          rep_nx = 1'b1;
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt_inc(cnt);
        end
      end
      DEB_REL: begin
        if (match) begin
          // Key came back before release was accepted: restart repeat delay.
          state_nx = HELD;
          cnt_nx   = '0;
        end else if (cnt == DEB_TC) begin
          down_nx  = 1'b0;
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc(cnt);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with short debounce/repeat timings.
module tb_key_event;

  logic       mclk;
  logic       rst;
  logic [4:0] key_code;
  logic       key_evt;
  logic [4:0] key_val;
  logic       key_rep;
  logic       key_down;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] code;
    logic       evt;
    logic [4:0] val;
    logic       rep;
    logic       down;
  } vec_t;

  vec_t vq[$];

  key_event #(
    .DEB_CYC(4),
    .REP_DLY(10),
    .REP_PER(3)
  ) dut (
    .mclk    (mclk),
    .rst     (rst),
    .key_code(key_code),
    .key_evt (key_evt),
    .key_val (key_val),
    .key_rep (key_rep),
    .key_down(key_down)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic void add(input logic [4:0] c, input logic e, input logic [4:0] v,
                              input logic r, input logic d);
    vec_t x;
    x.code = c; x.evt = e; x.val = v; x.rep = r; x.down = d;
    vq.push_back(x);
  endfunction

  task automatic check(input string name, input int idx, input logic e, input logic [4:0] v,
                       input logic r, input logic d);
    checks++;
    if (key_evt !== e || key_val !== v || key_rep !== r || key_down !== d) begin
      errors++;
      $display("FAIL %s[%0d]: got evt=%b val=%0d rep=%b down=%b, want evt=%b val=%0d rep=%b down=%b",
               name, idx, key_evt, key_val, key_rep, key_down, e, v, r, d);
    end
  endtask

  // Drive a sample, let the next rising edge register it, check just after.
  task automatic step(input string name, input int idx, input logic [4:0] c, input logic e,
                      input logic [4:0] v, input logic r, input logic d);
    key_code = c;
    @(posedge mclk);
    #1;
    check(name, idx, e, v, r, d);
  endtask

  initial begin
    int nevt;
    logic e;
    rst = 1'b1;
    key_code = 5'd0;
    @(posedge mclk);
    @(posedge mclk);
    #1;
    check("reset", 0, 1'b0, 5'd0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    @(posedge mclk);
    #1;

    // Clean press of key 5, release after 8 samples.
    for (int i = 0; i < 3; i++) add(5'd5, 0, 5'd0, 0, 0);
    add(5'd5, 1, 5'd5, 0, 1);
    for (int i = 0; i < 4; i++) add(5'd5, 0, 5'd5, 0, 1);
    for (int i = 0; i < 3; i++) add(5'd0, 0, 5'd5, 0, 1);
    add(5'd0, 0, 5'd5, 0, 0);
    add(5'd0, 0, 5'd5, 0, 0);
    // Bounce: never four consecutive samples.
    for (int i = 0; i < 3; i++) add(5'd5, 0, 5'd5, 0, 0);
    add(5'd0, 0, 5'd5, 0, 0);
    for (int i = 0; i < 3; i++) add(5'd5, 0, 5'd5, 0, 0);
    add(5'd0, 0, 5'd5, 0, 0);
    add(5'd0, 0, 5'd5, 0, 0);
    // Out-of-range code behaves as no key.
    for (int i = 0; i < 20; i++) add(5'd20, 0, 5'd5, 0, 0);
    add(5'd0, 0, 5'd5, 0, 0);
    // Release glitch on key 7: repeat delay restarts when the key returns.
    for (int i = 0; i < 3; i++) add(5'd7, 0, 5'd5, 0, 0);
    add(5'd7, 1, 5'd7, 0, 1);
    add(5'd0, 0, 5'd7, 0, 1);
    add(5'd0, 0, 5'd7, 0, 1);
    for (int i = 0; i < 10; i++) add(5'd7, 0, 5'd7, 0, 1);
    add(5'd7, 1, 5'd7, 1, 1);
    for (int i = 0; i < 3; i++) add(5'd0, 0, 5'd7, 1, 1);
    add(5'd0, 0, 5'd7, 1, 0);
    add(5'd0, 0, 5'd7, 1, 0);
    // Key 9 held, then key 2 replaces it: 2 counts as release of 9 first.
    for (int i = 0; i < 3; i++) add(5'd9, 0, 5'd7, 1, 0);
    add(5'd9, 1, 5'd9, 0, 1);
    for (int i = 0; i < 3; i++) add(5'd2, 0, 5'd9, 0, 1);
    add(5'd2, 0, 5'd9, 0, 0);
    for (int i = 0; i < 3; i++) add(5'd2, 0, 5'd9, 0, 0);
    add(5'd2, 1, 5'd2, 0, 1);
    for (int i = 0; i < 3; i++) add(5'd0, 0, 5'd2, 0, 1);
    add(5'd0, 0, 5'd2, 0, 0);

    for (int i = 0; i < vq.size(); i++)
      step("vec", i, vq[i].code, vq[i].evt, vq[i].val, vq[i].rep, vq[i].down);

    // Auto-repeat: key 12 held for 30 samples.
    nevt = 0;
    for (int k = 0; k < 30; k++) begin
      e = (k == 3) || (k >= 13 && ((k - 13) % 3 == 0));
      step("repeat", k, 5'd12, e, (k < 3) ? 5'd2 : 5'd12, (k >= 13), (k >= 3));
      if (key_evt === 1'b1) nevt++;
    end
    checks++;
    if (nevt != 7) begin
      errors++;
      $display("FAIL repeat_count: got %0d events, want 7", nevt);
    end
    for (int k = 0; k < 4; k++) step("repeat_rel", k, 5'd0, 0, 5'd12, 1, (k < 3));

    // Reset in REPEAT with key 3 still held.
    for (int k = 0; k < 17; k++) begin
      e = (k == 3) || (k == 13) || (k == 16);
      step("pre_rst", k, 5'd3, e, (k < 3) ? 5'd12 : 5'd3, (k < 3) || (k >= 13), (k >= 3));
    end
    #2 rst = 1'b1;
    #1;
    check("rst_async", 0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(posedge mclk);
    #1;
    check("rst_hold", 0, 1'b0, 5'd0, 1'b0, 1'b0);
    #3 rst = 1'b0;
    for (int k = 0; k < 3; k++) step("post_rst", k, 5'd3, 0, 5'd0, 0, 0);
    step("post_rst", 3, 5'd3, 1, 5'd3, 0, 1);
    step("post_rst", 4, 5'd3, 0, 5'd3, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
